// File: rtl/mul_vector_pkg.sv
// Shared state type, default geometry and counter sizing helpers for the
// limb-serial vector multiplier.
package mul_vector_pkg;

  localparam int unsigned DEF_LIMB_W  = 16;
  localparam int unsigned DEF_N_LIMBS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // Step counter walks every (i, j) limb pair once.
  function automatic int unsigned step_cnt_w(input int unsigned n_limbs);
    return idx_w(n_limbs * n_limbs);
  endfunction

endpackage

// File: rtl/mul_limb_mac.sv
// One schoolbook step: accumulator plus a_i*b_j shifted to limb position
// (i+j). Purely combinational.
module mul_limb_mac
  import mul_vector_pkg::*;
#(
  parameter int unsigned LIMB_W  = DEF_LIMB_W,
  parameter int unsigned N_LIMBS = DEF_N_LIMBS,
  localparam int unsigned ACC_W  = 2 * N_LIMBS * LIMB_W,
  localparam int unsigned OFF_W  = idx_w(2 * N_LIMBS)
) (
  input  logic [LIMB_W-1:0] a_limb,
  input  logic [LIMB_W-1:0] b_limb,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum_c
);

  logic [2*LIMB_W-1:0] prod;
  logic [ACC_W-1:0]    shifted;

  // Full-width limb product, placed at its limb offset; wrap is harmless
  // because the final product always fits the accumulator.
  always_comb begin
    prod    = (2 * LIMB_W)'(a_limb) * (2 * LIMB_W)'(b_limb);
    shifted = ACC_W'(prod) << (32'(offset) * LIMB_W);
    sum_c   = acc + shifted;
  end

endmodule

// File: rtl/mul_vector_seq.sv
// Limb-serial unsigned vector multiplier with valid/ready on both sides.
// Optional MUL_ZERO_SKIP_EN: a zero operand jumps straight to DONE with y=0.
module mul_vector_seq
  import mul_vector_pkg::*;
#(
  parameter int unsigned LIMB_W  = DEF_LIMB_W,
  parameter int unsigned N_LIMBS = DEF_N_LIMBS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_LIMBS*LIMB_W-1:0]     a,
  input  logic [N_LIMBS*LIMB_W-1:0]     b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*N_LIMBS*LIMB_W-1:0]   y
);

  localparam int unsigned OP_W   = N_LIMBS * LIMB_W;
  localparam int unsigned ACC_W  = 2 * OP_W;
  localparam int unsigned STEP_W = step_cnt_w(N_LIMBS);
  localparam int unsigned OFF_W  = idx_w(2 * N_LIMBS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_LIMBS * N_LIMBS - 1);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    y_d;
  logic                in_ready_d;
  logic                out_valid_d;

  logic [STEP_W-1:0]   i_c, j_c;
  logic [LIMB_W-1:0]   a_limb_c, b_limb_c;
  logic [OFF_W-1:0]    offset_c;
  logic [ACC_W-1:0]    mac_sum_c;
  logic                accept_c;
`ifdef MUL_ZERO_SKIP_EN
  logic                zero_op_c;
`endif

  // Limb pair for the current step: i runs fastest, over operand A.
  always_comb begin
    i_c      = STEP_W'(32'(step_q) % N_LIMBS);
    j_c      = STEP_W'(32'(step_q) / N_LIMBS);
    a_limb_c = LIMB_W'(a_q >> (32'(i_c) * LIMB_W));
    b_limb_c = LIMB_W'(b_q >> (32'(j_c) * LIMB_W));
    offset_c = OFF_W'(32'(i_c) + 32'(j_c));
  end

  mul_limb_mac #(
    .LIMB_W  (LIMB_W),
    .N_LIMBS (N_LIMBS)
  ) u_mac (
    .a_limb (a_limb_c),
    .b_limb (b_limb_c),
    .offset (offset_c),
    .acc    (acc_q),
    .sum_c  (mac_sum_c)
  );

  assign accept_c = (state_q == IDLE) && in_valid && in_ready;
`ifdef MUL_ZERO_SKIP_EN
  assign zero_op_c = (a == '0) || (b == '0);
`endif

  // Next-state, datapath and registered-output control.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    y_d         = y;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          a_d        = a;
          b_d        = b;
          acc_d      = '0;
          y_d        = '0;
          step_d     = '0;
          in_ready_d = 1'b0;
`ifdef MUL_ZERO_SKIP_EN
          if (zero_op_c) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = MUL;
          end
`else
          state_d = MUL;
`endif
        end
      end

      MUL: begin
        acc_d  = mac_sum_c;
        step_d = step_q + STEP_W'(1);
        // Result is published on the same edge that commits the last step.
        if (step_q == LAST_STEP) begin
          state_d     = DONE;
          step_d      = '0;
          y_d         = mac_sum_c;
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        step_d      = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      step_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      y         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      y         <= y_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mul_vector_seq.sv
// Randomised self-checking bench: 2x16-bit and 4x8-bit instances against a
// plain 64-bit product model with latency derived from the limb count.
module tb_mul_vector_seq;

`ifdef MUL_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid0, in_valid1;
  logic        out_ready0, out_ready1;
  logic [31:0] a0, b0, a1, b1;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [63:0] y0, y1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_vector_seq dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .a         (a0),
    .b         (b0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .y         (y0)
  );

  mul_vector_seq #(
    .LIMB_W  (8),
    .N_LIMBS (4)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .y         (y1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] get_y(input int s);
    return (s != 0) ? y1 : y0;
  endfunction

  function automatic logic get_ov(input int s);
    return (s != 0) ? out_valid1 : out_valid0;
  endfunction

  function automatic logic get_ir(input int s);
    return (s != 0) ? in_ready1 : in_ready0;
  endfunction

  task automatic drive(input int s, input logic v, input logic [31:0] aa, input logic [31:0] bb);
    if (s != 0) begin
      in_valid1 = v; a1 = aa; b1 = bb;
    end else begin
      in_valid0 = v; a0 = aa; b0 = bb;
    end
  endtask

  task automatic set_or(input int s, input logic r);
    if (s != 0) out_ready1 = r;
    else        out_ready0 = r;
  endtask

  // Cycles from acceptance to first out_valid: one per limb pair, plus one.
  function automatic int exp_lat(input int s, input logic [31:0] aa, input logic [31:0] bb);
    int n;
    n = (s != 0) ? 4 : 2;
    return (ZSKIP && (aa == 32'd0 || bb == 32'd0)) ? 1 : n * n + 1;
  endfunction

  // One full transaction; in_valid stays high with junk while busy.
  task automatic issue(input int s, input logic [31:0] aa, input logic [31:0] bb,
                       input int stall, input string tag);
    int          lat;
    int          wait_c;
    int          n_exp;
    logic [63:0] exp_y;
    exp_y  = 64'(aa) * 64'(bb);
    n_exp  = exp_lat(s, aa, bb);
    wait_c = 0;
    while (!get_ir(s) && wait_c < 100) begin
      @(negedge clk);
      wait_c++;
    end
    check({tag, "_idle_rdy"}, 64'(get_ir(s)), 64'd1);
    drive(s, 1'b1, aa, bb);
    set_or(s, stall == 0);
    @(negedge clk);
    lat = 1;
    drive(s, 1'b1, $urandom, $urandom);
    check({tag, "_busy_rdy"}, 64'(get_ir(s)), 64'd0);
    if (n_exp > 1) check({tag, "_clr_y"}, get_y(s), 64'd0);
    while (!get_ov(s) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(n_exp));
    check({tag, "_y"}, get_y(s), exp_y);
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      check({tag, "_hold_y"}, get_y(s), exp_y);
      check({tag, "_hold_v"}, 64'(get_ov(s)), 64'd1);
      check({tag, "_hold_rdy"}, 64'(get_ir(s)), 64'd0);
    end
    set_or(s, 1'b1);
    @(negedge clk);
    check({tag, "_post_v"}, 64'(get_ov(s)), 64'd0);
    check({tag, "_post_rdy"}, 64'(get_ir(s)), 64'd1);
    check({tag, "_post_y"}, get_y(s), exp_y);
    drive(s, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          rs;

    // Reset with operands offered: nothing may be accepted.
    rst_n = 1'b0;
    drive(0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0003);
    drive(1, 1'b1, 32'h1234_5678, 32'h0000_0009);
    set_or(0, 1'b1);
    set_or(1, 1'b1);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_rdy", 64'(get_ir(s)), 64'd1);
      check("rst_v", 64'(get_ov(s)), 64'd0);
      check("rst_y", get_y(s), 64'd0);
    end
    drive(0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rel_rdy", 64'(get_ir(s)), 64'd1);
      check("rel_v", 64'(get_ov(s)), 64'd0);
    end

    issue(0, 32'h0001_0002, 32'h0003_0004, 0, "dflt");
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max");
    issue(0, 32'h0102_0304, 32'h0A0B_0C0D, 10, "bp");
    issue(0, 32'h1234_0005, 32'h0007_ABCD, 0, "bp_next");

    // Abandon an operation two cycles in.
    drive(0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_v", 64'(get_ov(0)), 64'd0);
    check("mid_rst_rdy", 64'(get_ir(0)), 64'd1);
    check("mid_rst_y", get_y(0), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("mid_rst_quiet", 64'(get_ov(0)), 64'd0);
    end
    issue(0, 32'd5, 32'd7, 0, "after_rst");

    issue(1, 32'hFFFF_FFFF, 32'h0000_0002, 0, "n4");
    issue(1, 32'h0000_0000, 32'h89AB_CDEF, 0, "n4_zero");
    issue(0, 32'h0000_0000, 32'hFFFF_FFFF, 2, "n2_zero");
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, "n4_max");

    for (int k = 0; k < 30; k++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'd0;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      issue(rs, ra, rb, $urandom_range(0, 3), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
